// File: rtl/mvu_pkg.sv
// Shared defaults and FSM encoding for the MVU bit-serial shift-accumulator.
// Optional build macro used by this block: MVU_SHACC_SAT_EN.
package mvu_pkg;

  localparam int MVU_N    = 64;
  localparam int MVU_WIN  = 16;
  localparam int MVU_WACC = 32;
  localparam int MVU_MAXP = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/mvu_shacc_lane.sv
// One lane of the shift-accumulator: acc = 2*acc +/- plane, or +/- plane on a group's first beat.
// MVU_SHACC_SAT_EN selects clamped arithmetic and adds the clamp port; otherwise wraps modulo 2^WACC.
module mvu_shacc_lane #(
  parameter int WIN  = 16,
  parameter int WACC = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            en,
  input  logic            first,
  input  logic            neg,
  input  logic [WIN-1:0]  din,
  output logic [WACC-1:0] acc_nxt
`ifdef MVU_SHACC_SAT_EN
  ,
  output logic            clamp
`endif
);

  logic [WACC-1:0]       acc;
  logic signed [WIN-1:0] din_s;

  assign din_s = din;

`ifdef MVU_SHACC_SAT_EN
  // Two guard bits hold 2*acc +/- plane exactly before the clamp decision.
  localparam int WX = WACC + 2;
  localparam logic signed [WX-1:0] MAXV = {3'b000, {(WACC-1){1'b1}}};
  localparam logic signed [WX-1:0] MINV = {3'b111, {(WACC-1){1'b0}}};

  logic signed [WX-1:0] base;
  logic signed [WX-1:0] term;
  logic signed [WX-1:0] sum;

  always_comb begin
    base    = '0;
    term    = WX'(din_s);
    sum     = '0;
    clamp   = 1'b0;
    acc_nxt = '0;
    if (!first) begin
      base = {acc[WACC-1], acc, 1'b0};
    end
    sum = neg ? (base - term) : (base + term);
    if (sum > MAXV) begin
      clamp   = 1'b1;
      acc_nxt = MAXV[WACC-1:0];
    end else if (sum < MINV) begin
      clamp   = 1'b1;
      acc_nxt = MINV[WACC-1:0];
    end else begin
      acc_nxt = sum[WACC-1:0];
    end
  end
`else
  logic [WACC-1:0] base;
  logic [WACC-1:0] term;

  always_comb begin
    base    = '0;
    term    = WACC'(din_s);
    acc_nxt = '0;
    if (!first) begin
      base = {acc[WACC-2:0], 1'b0};
    end
    acc_nxt = neg ? (base - term) : (base + term);
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/mvu_shacc.sv
// Bit-serial shift-accumulator after the MVU dot-product array; 1 beat/cycle, result one cycle after last beat.
// in_ready = !out_valid || out_ready gates every beat. Build macro MVU_SHACC_SAT_EN enables clamping and sat.
module mvu_shacc
  import mvu_pkg::*;
#(
  parameter int  N    = MVU_N,
  parameter int  WIN  = MVU_WIN,
  parameter int  WACC = MVU_WACC,
  parameter int  MAXP = MVU_MAXP,
  localparam int CW   = $clog2(MAXP + 1)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*WIN-1:0]  in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*WACC-1:0] out_data,
  output logic [CW-1:0]     out_planes,
  output logic              err,
  output logic              sat
);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              fire;
  logic              acc_en;
  logic              done;
  logic              cnt_full;
  logic              err_set;
  logic [N*WACC-1:0] acc_nxt;
`ifdef MVU_SHACC_SAT_EN
  logic [N-1:0]      clamp;
`endif

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign cnt_full = (cnt == CW'(MAXP));
  assign done     = acc_en && in_last;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (acc_en) begin
        cnt <= cnt_nxt;
      end
    end
  end

  // A non-first beat with no open group is dropped; a first beat always (re)starts a group.
  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    err_set   = 1'b0;
    cnt_nxt   = cnt;
    if (fire) begin
      unique case (state)
        ST_IDLE: begin
          if (in_first) begin
            acc_en    = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = in_last ? ST_IDLE : ST_ACC;
          end else begin
            err_set = 1'b1;
          end
        end
        ST_ACC: begin
          acc_en = 1'b1;
          if (in_first) begin
            err_set = 1'b1;
            cnt_nxt = CW'(1);
          end else begin
            err_set = cnt_full;
            cnt_nxt = cnt_full ? cnt : (cnt + CW'(1));
          end
          state_nxt = in_last ? ST_IDLE : ST_ACC;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mvu_shacc_lane #(
      .WIN  (WIN),
      .WACC (WACC)
    ) u_lane (
      .clk     (clk),
      .clr_n   (clr_n),
      .en      (acc_en),
      .first   (in_first),
      .neg     (in_neg),
      .din     (in_data[i*WIN +: WIN]),
      .acc_nxt (acc_nxt[i*WACC +: WACC])
`ifdef MVU_SHACC_SAT_EN
      ,
      .clamp   (clamp[i])
`endif
    );
  end

  // A last beat can only fire when the register is free or draining, so a held result never changes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_planes <= '0;
    end else if (done) begin
      out_valid  <= 1'b1;
      out_data   <= acc_nxt;
      out_planes <= cnt_nxt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

`ifdef MVU_SHACC_SAT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sat <= 1'b0;
    end else if (acc_en && (|clamp)) begin
      sat <= 1'b1;
    end
  end
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_mvu_shacc.sv
// Directed bench for mvu_shacc with N=4, WIN=16, WACC=8, MAXP=4; expectations are hand-computed.
module tb_mvu_shacc;

  localparam int N    = 4;
  localparam int WIN  = 16;
  localparam int WACC = 8;
  localparam int MAXP = 4;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*WIN-1:0]  in_data;
  logic              in_first;
  logic              in_last;
  logic              in_neg;
  logic              out_valid;
  logic              out_ready;
  logic [N*WACC-1:0] out_data;
  logic [2:0]        out_planes;
  logic              err;
  logic              sat;

  int n_chk  = 0;
  int n_fail = 0;

  mvu_shacc #(
    .N    (N),
    .WIN  (WIN),
    .WACC (WACC),
    .MAXP (MAXP)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_first   (in_first),
    .in_last    (in_last),
    .in_neg     (in_neg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_planes (out_planes),
    .err        (err),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [N*WIN-1:0] pin(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [N*WACC-1:0] pout(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat, lets it be sampled on the next rising edge, returns 1 time unit later.
  task automatic beat(input logic f, input logic l, input logic ng, input logic [N*WIN-1:0] d);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_neg   = ng;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_neg   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr_n    = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_neg    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_planes", 64'(out_planes), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Four planes MSB-first, sign plane negated.
    beat(1'b1, 1'b0, 1'b1, pin(1, 3, 0, 1));
    beat(1'b0, 1'b0, 1'b0, pin(0, -2, 0, 1));
    beat(1'b0, 1'b0, 1'b0, pin(1, 0, 0, 1));
    chk("g4_not_yet_valid", 64'(out_valid), 64'd0);
    beat(1'b0, 1'b1, 1'b0, pin(1, 1, 0, 1));
    chk("g4_valid", 64'(out_valid), 64'd1);
    chk("g4_data", 64'(out_data), 64'(pout(-5, -31, 0, -1)));
    chk("g4_planes", 64'(out_planes), 64'd4);
    idle();
    chk("g4_drained", 64'(out_valid), 64'd0);

    // Single-plane group.
    beat(1'b1, 1'b1, 1'b0, pin(7, -3, 0, 100));
    chk("g1_valid", 64'(out_valid), 64'd1);
    chk("g1_data", 64'(out_data), 64'(pout(7, -3, 0, 100)));
    chk("g1_planes", 64'(out_planes), 64'd1);

    // Stall: downstream not ready, pending single-plane beat must wait.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_neg    = 1'b0;
    in_data   = pin(5, 6, -7, -8);
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data_held", 64'(out_data), 64'(pout(7, -3, 0, 100)));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("nogap_valid", 64'(out_valid), 64'd1);
    chk("nogap_data", 64'(out_data), 64'(pout(5, 6, -7, -8)));

    // Back-to-back groups at full rate.
    beat(1'b1, 1'b0, 1'b0, pin(1, 2, 3, 4));
    chk("b2b_mid_valid", 64'(out_valid), 64'd0);
    beat(1'b0, 1'b1, 1'b0, pin(1, 1, 1, 1));
    chk("b2b_a_data", 64'(out_data), 64'(pout(3, 5, 7, 9)));
    chk("b2b_a_planes", 64'(out_planes), 64'd2);
    beat(1'b1, 1'b1, 1'b0, pin(9, 9, 9, 9));
    chk("b2b_b_valid", 64'(out_valid), 64'd1);
    chk("b2b_b_data", 64'(out_data), 64'(pout(9, 9, 9, 9)));
    idle();

    // Non-first beat with no open group.
    do_reset();
    beat(1'b0, 1'b0, 1'b0, pin(5, 5, 5, 5));
    chk("orphan_err", 64'(err), 64'd1);
    chk("orphan_no_valid", 64'(out_valid), 64'd0);

    // First beat during an open group restarts it.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, pin(10, 10, 10, 10));
    chk("restart_err_before", 64'(err), 64'd0);
    beat(1'b1, 1'b1, 1'b0, pin(2, -2, 3, 0));
    chk("restart_err", 64'(err), 64'd1);
    chk("restart_data", 64'(out_data), 64'(pout(2, -2, 3, 0)));
    chk("restart_planes", 64'(out_planes), 64'd1);
    idle();

    // Overflow of an 8-bit accumulator.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, pin(127, -100, 10, 0));
    beat(1'b0, 1'b1, 1'b0, pin(127, -100, 5, 0));
`ifdef MVU_SHACC_SAT_EN
    chk("ovf_data", 64'(out_data), 64'(pout(127, -128, 25, 0)));
    chk("ovf_sat", 64'(sat), 64'd1);
`else
    chk("ovf_data", 64'(out_data), 64'(pout(125, -44, 25, 0)));
    chk("ovf_sat", 64'(sat), 64'd0);
`endif
    idle();

    // More than MAXP planes: fifth plane still accumulated, count saturates.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, pin(1, 1, 1, 1));
    beat(1'b0, 1'b0, 1'b0, pin(1, 1, 1, 1));
    beat(1'b0, 1'b0, 1'b0, pin(1, 1, 1, 1));
    beat(1'b0, 1'b0, 1'b0, pin(1, 1, 1, 1));
    chk("maxp_err_before", 64'(err), 64'd0);
    beat(1'b0, 1'b1, 1'b0, pin(1, 1, 1, 1));
    chk("maxp_err", 64'(err), 64'd1);
    chk("maxp_data", 64'(out_data), 64'(pout(31, 31, 31, 31)));
    chk("maxp_planes", 64'(out_planes), 64'd4);
    idle();

    // Asynchronous reset mid-group closes the group.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, pin(1, 1, 1, 1));
    in_valid = 1'b0;
    clr_n    = 1'b0;
    #1;
    chk("midgrp_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b0, 1'b1, 1'b0, pin(2, 2, 2, 2));
    chk("midgrp_tail_err", 64'(err), 64'd1);
    chk("midgrp_tail_no_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    clr_n    = 1'b0;
    #1;
    chk("rst_clears_err", 64'(err), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    beat(1'b1, 1'b1, 1'b0, pin(3, 3, 3, 3));
    chk("held_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    clr_n    = 1'b0;
    #1;
    chk("held_rst_valid", 64'(out_valid), 64'd0);
    chk("held_rst_data", 64'(out_data), 64'd0);
    chk("held_rst_planes", 64'(out_planes), 64'd0);
    chk("held_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
